// File: rtl/instr_pkg.sv
// ---------------------------------------------------------------------------
// instr_pkg
//   Shared definitions for the 16-bit instruction word used by the
//   instruction encoder and the instruction decoder.
//   - Field bit positions of the word.
//   - Opcode nibbles (word[15:12]) that do not write a register.
//   - regwe_of(): register-write rule. The decoder uses the same function,
//     so the hint produced here always agrees with the decoder.
// ---------------------------------------------------------------------------
package instr_pkg;

  localparam int INSTR_W  = 16;

  localparam int AOP_MSB  = 15;
  localparam int AOP_LSB  = 11;
  localparam int SELA_MSB = 10;
  localparam int SELA_LSB = 8;
  localparam int SELB_MSB = 7;
  localparam int SELB_LSB = 5;
  localparam int SELD_MSB = 4;
  localparam int SELD_LSB = 2;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  localparam logic [3:0] NOWR_NIB_0 = 4'b0111;
  localparam logic [3:0] NOWR_NIB_1 = 4'b1100;
  localparam logic [3:0] NOWR_NIB_2 = 4'b1101;

  function automatic logic regwe_of(input logic [3:0] nib);
    return !((nib == NOWR_NIB_0) || (nib == NOWR_NIB_1) || (nib == NOWR_NIB_2));
  endfunction

endpackage

// File: rtl/instruction_encoder_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with a combinational head read port.
//   Ports:
//     clk, rst_n      clock, async active-low reset (pointers and count only)
//     push, wdata     write request and data; ignored when full
//     pop             read request; ignored when empty, advances the head
//     rdata           current head entry (valid when count != 0)
//     count           occupancy, 0..DEPTH
//   DEPTH must be a power of two >= 2 so pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
//   Packs decoded instruction fields into 16-bit words, buffers them in a
//   FIFO and issues one word per cycle to the instruction decoder.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     in_valid/in_ready   field-set handshake (in_ready = count != DEPTH)
//     in_aluop..in_immform decoded fields; immform selects imm vs reg form
//     stall               holds off issue while high
//     instr, en           issued word and its one-cycle issue strobe
//     regwe_hint          predicted decoder register-write for instr
//     count               FIFO occupancy
//     err                 one-cycle reject pulse
//   Build option INSTR_ENC_IMM_CHECK_EN: immediate-form sets with nonzero
//   in_imm[15:8] are handshaken but dropped and flagged on err. Without it
//   the upper immediate bits are truncated and err stays 0.
// ---------------------------------------------------------------------------
module instruction_encoder
  import instr_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_aluop,
  input  logic [2:0]         in_selA,
  input  logic [2:0]         in_selB,
  input  logic [2:0]         in_selD,
  input  logic [15:0]        in_imm,
  input  logic               in_immform,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr,
  output logic               en,
  output logic               regwe_hint,
  output logic [CW-1:0]      count,
  output logic               err
);

  logic [INSTR_W-1:0] word;
  logic               word_hint;
  logic               accept;
  logic               reject;
  logic               push;
  logic               pop;
  logic [INSTR_W:0]   head;
  logic [CW-1:0]      fifo_count;

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               en_q, en_d;
  logic               regwe_hint_q, regwe_hint_d;
  logic               err_q, err_d;

  always_comb begin
    word = '0;
    word[AOP_MSB:AOP_LSB]   = in_aluop;
    word[SELA_MSB:SELA_LSB] = in_selA;
    if (in_immform) begin
      word[IMM_MSB:IMM_LSB] = in_imm[7:0];
    end else begin
      word[SELB_MSB:SELB_LSB] = in_selB;
      word[SELD_MSB:SELD_LSB] = in_selD;
    end
  end

  assign word_hint = regwe_of(word[15:12]);
  assign in_ready  = (fifo_count != CW'(DEPTH));
  assign accept    = in_valid && in_ready;

`ifdef INSTR_ENC_IMM_CHECK_EN
  assign reject = accept && in_immform && (in_imm[15:8] != 8'h00);
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[15:8];
  assign reject        = 1'b0;
`endif

  assign push = accept && !reject;
  // Pop decision uses the pre-edge count, so a word pushed into an empty
  // FIFO cannot bypass straight to instr on the same edge.
  assign pop  = !stall && (fifo_count != '0);

  sync_fifo #(
    .WIDTH (INSTR_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({word_hint, word}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

  always_comb begin
    instr_d      = instr_q;
    regwe_hint_d = regwe_hint_q;
    en_d         = pop;
    err_d        = reject;
    if (pop) begin
      instr_d      = head[INSTR_W-1:0];
      regwe_hint_d = head[INSTR_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q      <= '0;
      en_q         <= 1'b0;
      regwe_hint_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      instr_q      <= instr_d;
      en_q         <= en_d;
      regwe_hint_q <= regwe_hint_d;
      err_q        <= err_d;
    end
  end

  assign instr      = instr_q;
  assign en         = en_q;
  assign regwe_hint = regwe_hint_q;
  assign err        = err_q;
  assign count      = fifo_count;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_aluop;
  logic [2:0]  in_selA;
  logic [2:0]  in_selB;
  logic [2:0]  in_selD;
  logic [15:0] in_imm;
  logic        in_immform;
  logic        stall;
  logic [15:0] instr;
  logic        en;
  logic        regwe_hint;
  logic [2:0]  count;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  instruction_encoder #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_aluop   (in_aluop),
    .in_selA    (in_selA),
    .in_selB    (in_selB),
    .in_selD    (in_selD),
    .in_imm     (in_imm),
    .in_immform (in_immform),
    .stall      (stall),
    .instr      (instr),
    .en         (en),
    .regwe_hint (regwe_hint),
    .count      (count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d);
    in_valid = 1'b1; in_immform = 1'b0;
    in_aluop = op; in_selA = a; in_selB = b; in_selD = d; in_imm = 16'hFFFF;
  endtask

  task automatic set_imm(input logic [4:0] op, input logic [2:0] a, input logic [15:0] imm);
    in_valid = 1'b1; in_immform = 1'b1;
    in_aluop = op; in_selA = a; in_selB = 3'd7; in_selD = 3'd7; in_imm = imm;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    in_valid = 1'b0; in_aluop = '0; in_selA = '0; in_selB = '0; in_selD = '0;
    in_imm = '0; in_immform = 1'b0;

    // Reset, with a push attempt that must be ignored
    #2;
    set_reg(5'b00010, 3'd1, 3'd2, 3'd3);
    tick();
    chk("rst_instr", instr, 16'h0000);
    chk("rst_en", {15'd0, en}, 16'd0);
    chk("rst_hint", {15'd0, regwe_hint}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_count", {13'd0, count}, 16'd0);
    chk("rst_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Register form
    set_reg(5'b00010, 3'd1, 3'd2, 3'd3);
    tick();
    chk("reg_cnt_after_push", {13'd0, count}, 16'd1);
    chk("reg_no_bypass", {15'd0, en}, 16'd0);
    in_valid = 1'b0;
    tick();
    chk("reg_instr", instr, 16'h114C);
    chk("reg_en", {15'd0, en}, 16'd1);
    chk("reg_hint", {15'd0, regwe_hint}, 16'd1);
    chk("reg_cnt_after_pop", {13'd0, count}, 16'd0);
    tick();
    chk("reg_en_pulse", {15'd0, en}, 16'd0);
    chk("reg_instr_hold", instr, 16'h114C);

    // Immediate form, streamed back to back
    set_imm(5'b01000, 3'd3, 16'h00A5);
    tick();
    chk("imm_cnt1", {13'd0, count}, 16'd1);
    set_imm(5'b01110, 3'd3, 16'h00A5);
    tick();
    chk("imm1_instr", instr, 16'h43A5);
    chk("imm1_hint", {15'd0, regwe_hint}, 16'd1);
    chk("imm1_en", {15'd0, en}, 16'd1);
    chk("stream_cnt", {13'd0, count}, 16'd1);
    set_imm(5'b11001, 3'd3, 16'h00A5);
    tick();
    chk("imm2_instr", instr, 16'h73A5);
    chk("imm2_hint", {15'd0, regwe_hint}, 16'd0);
    chk("imm2_en", {15'd0, en}, 16'd1);
    in_valid = 1'b0;
    tick();
    chk("imm3_instr", instr, 16'hCBA5);
    chk("imm3_hint", {15'd0, regwe_hint}, 16'd0);
    chk("imm3_en", {15'd0, en}, 16'd1);
    chk("imm_cnt0", {13'd0, count}, 16'd0);

    // Backpressure: five pushes under stall, the fifth is refused
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_reg(5'b00001, 3'(i), 3'd0, 3'd0);
      tick();
    end
    chk("bp_cnt_full", {13'd0, count}, 16'd4);
    chk("bp_ready_low", {15'd0, in_ready}, 16'd0);
    chk("bp_no_en", {15'd0, en}, 16'd0);
    set_reg(5'b00001, 3'd7, 3'd0, 3'd0);
    tick();
    chk("bp_cnt_5th", {13'd0, count}, 16'd4);
    in_valid = 1'b0;
    stall = 1'b0;
    tick();
    chk("bp_pop0", instr, 16'h0800);
    chk("bp_en0", {15'd0, en}, 16'd1);
    chk("bp_ready_back", {15'd0, in_ready}, 16'd1);
    chk("bp_cnt3", {13'd0, count}, 16'd3);
    tick();
    chk("bp_pop1", instr, 16'h0900);
    chk("bp_en1", {15'd0, en}, 16'd1);
    tick();
    chk("bp_pop2", instr, 16'h0A00);
    chk("bp_en2", {15'd0, en}, 16'd1);
    tick();
    chk("bp_pop3", instr, 16'h0B00);
    chk("bp_en3", {15'd0, en}, 16'd1);
    tick();
    chk("bp_drained_en", {15'd0, en}, 16'd0);
    chk("bp_drained_instr", instr, 16'h0B00);
    chk("bp_drained_cnt", {13'd0, count}, 16'd0);

    // Simultaneous push and pop at count 2
    stall = 1'b1;
    set_reg(5'b00011, 3'd1, 3'd0, 3'd0);
    tick();
    set_reg(5'b00011, 3'd2, 3'd0, 3'd0);
    tick();
    chk("pp_cnt2", {13'd0, count}, 16'd2);
    stall = 1'b0;
    set_reg(5'b00011, 3'd3, 3'd0, 3'd0);
    tick();
    chk("pp_cnt_hold", {13'd0, count}, 16'd2);
    chk("pp_first", instr, 16'h1900);
    chk("pp_en", {15'd0, en}, 16'd1);
    in_valid = 1'b0;
    tick();
    chk("pp_second", instr, 16'h1A00);
    tick();
    chk("pp_third", instr, 16'h1B00);
    chk("pp_cnt0", {13'd0, count}, 16'd0);

    // Upper immediate bits set
    set_imm(5'b00100, 3'd0, 16'h01A5);
    tick();
    in_valid = 1'b0;
`ifdef INSTR_ENC_IMM_CHECK_EN
    chk("immchk_err", {15'd0, err}, 16'd1);
    chk("immchk_cnt", {13'd0, count}, 16'd0);
    tick();
    chk("immchk_err_pulse", {15'd0, err}, 16'd0);
    chk("immchk_no_en", {15'd0, en}, 16'd0);
    chk("immchk_instr_hold", instr, 16'h1B00);
`else
    chk("trunc_err", {15'd0, err}, 16'd0);
    chk("trunc_cnt", {13'd0, count}, 16'd1);
    tick();
    chk("trunc_instr", instr, 16'h20A5);
    chk("trunc_en", {15'd0, en}, 16'd1);
    chk("trunc_err2", {15'd0, err}, 16'd0);
`endif
    tick();

    // Reset mid-stream with count 3 while issuing
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_reg(5'b00011, 3'(i + 1), 3'd0, 3'd0);
      tick();
    end
    stall = 1'b0;
    set_reg(5'b00001, 3'd0, 3'd0, 3'd0);
    tick();
    chk("mid_cnt3", {13'd0, count}, 16'd3);
    chk("mid_en", {15'd0, en}, 16'd1);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {15'd0, en}, 16'd0);
    chk("mid_rst_instr", instr, 16'h0000);
    chk("mid_rst_cnt", {13'd0, count}, 16'd0);
    chk("mid_rst_ready", {15'd0, in_ready}, 16'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_en", {15'd0, en}, 16'd0);
    set_reg(5'b00010, 3'd1, 3'd2, 3'd3);
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_rst_instr", instr, 16'h114C);
    chk("post_rst_en", {15'd0, en}, 16'd1);
    chk("post_rst_cnt", {13'd0, count}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
